// File: rtl/cla_pkg.sv
// Shared types and lookahead helper for the pipelined CLA.
// Carries are formed as flat sums of products, never rippled.
package cla_pkg;

  localparam int GRP_W   = 4;
  localparam int MAX_GRP = 32;

  typedef struct packed {
    logic p;
    logic g;
  } grp_pg_t;

  // c[k] = G[k-1] | P[k-1]&c[k-1], expanded into independent product terms
  function automatic logic [MAX_GRP:0] lookahead_carries(
    input logic [MAX_GRP-1:0] p,
    input logic [MAX_GRP-1:0] g,
    input logic               c0
  );
    logic [MAX_GRP:0] c;
    logic             term;
    c    = '0;
    c[0] = c0;
    for (int k = 1; k <= MAX_GRP; k++) begin
      term = c0;
      for (int j = 0; j < k; j++) term &= p[j];
      c[k] = term;
      for (int j = 0; j < k; j++) begin
        term = g[j];
        for (int m = j + 1; m < k; m++) term &= p[m];
        c[k] |= term;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/cla_pipe_adder_if.sv
// Operand/result handshake bundle for the pipelined CLA.
// master drives operands and consumes results; slave is the adder.
interface cla_pipe_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;
  logic             pg;
  logic             gg;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, s, cout, ovf, pg, gg
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, s, cout, ovf, pg, gg
  );
endinterface

// File: rtl/cla4_group.sv
// 4-bit carry-lookahead group: sums, group P/G and carry into bit 3.
// Purely combinational; reused for P/G and for final sums.
module cla4_group
  import cla_pkg::*;
(
  input  logic [GRP_W-1:0] a_i,
  input  logic [GRP_W-1:0] b_i,
  input  logic             ci_i,
  output logic [GRP_W-1:0] s_o,
  output logic             p_o,
  output logic             g_o,
  output logic             c3_o
);
  logic [3:0] p;
  logic [3:0] g;
  logic [3:0] c;

  // bit-level lookahead inside the group
  always_comb begin
    p    = a_i ^ b_i;
    g    = a_i & b_i;
    c[0] = ci_i;
    c[1] = g[0] | (p[0] & ci_i);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci_i);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & ci_i);
    s_o  = p ^ c;
    p_o  = &p;
    g_o  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]);
    c3_o = c[3];
  end
endmodule

// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined CLA adder/subtractor with valid/ready flow.
// Stage 1 registers group P/G, stage 2 resolves carries and sums.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic            clk,
  input logic            rst,
  cla_pipe_adder_if.slave bus
);
  localparam int NGRP = WIDTH / GRP_W;

  if ((WIDTH % GRP_W) != 0 || WIDTH < 8 || NGRP > MAX_GRP) begin : g_bad_width
    $error("cla_pipe_adder: WIDTH must be a multiple of 4 and >= 8");
  end

  logic             adv1;
  logic             adv2;
  logic [WIDTH-1:0] bx;
  logic             cx;
  grp_pg_t [NGRP-1:0] gpg_d;

  logic             v1_q;
  logic [WIDTH-1:0] a1_q;
  logic [WIDTH-1:0] b1_q;
  logic             c1_q;
  grp_pg_t [NGRP-1:0] gpg_q;

  logic [MAX_GRP-1:0] p_ext;
  logic [MAX_GRP-1:0] g_ext;
  logic [MAX_GRP:0]   carry_full_unused;
  logic [MAX_GRP:0]   gen_full_unused;
  logic [NGRP:0]      carry;

  logic [WIDTH-1:0] s_d;
  logic             cout_d;
  logic             ovf_d;
  logic             pg_d;
  logic             gg_d;

  logic             v2_q;
  logic [WIDTH-1:0] s_q;
  logic             cout_q;
  logic             ovf_q;
  logic             pg_q;
  logic             gg_q;

  logic [WIDTH-1:0] s1_unused;
  logic [NGRP-1:0]  c31_unused;
  logic [NGRP-1:0]  p2_unused;
  logic [NGRP-1:0]  g2_unused;
  logic [NGRP-1:0]  c3_unused;

  assign adv2         = !v2_q || bus.out_ready;
  assign adv1         = !v1_q || adv2;
  assign bus.in_ready = adv1;

  assign bx = bus.sub ? ~bus.b : bus.b;
  assign cx = bus.sub | bus.cin;

  for (genvar k = 0; k < NGRP; k++) begin : g_grp
    cla4_group u_pg (
      .a_i  (bus.a[k*GRP_W +: GRP_W]),
      .b_i  (bx[k*GRP_W +: GRP_W]),
      .ci_i (1'b0),
      .s_o  (s1_unused[k*GRP_W +: GRP_W]),
      .p_o  (gpg_d[k].p),
      .g_o  (gpg_d[k].g),
      .c3_o (c31_unused[k])
    );
    cla4_group u_sum (
      .a_i  (a1_q[k*GRP_W +: GRP_W]),
      .b_i  (b1_q[k*GRP_W +: GRP_W]),
      .ci_i (carry[k]),
      .s_o  (s_d[k*GRP_W +: GRP_W]),
      .p_o  (p2_unused[k]),
      .g_o  (g2_unused[k]),
      .c3_o (c3_unused[k])
    );
  end

  // second-level lookahead over the registered group P/G
  always_comb begin
    p_ext = '0;
    g_ext = '0;
    for (int k = 0; k < NGRP; k++) begin
      p_ext[k] = gpg_q[k].p;
      g_ext[k] = gpg_q[k].g;
    end
    carry_full_unused = lookahead_carries(p_ext, g_ext, c1_q);
    gen_full_unused   = lookahead_carries(p_ext, g_ext, 1'b0);
  end

  assign carry  = carry_full_unused[NGRP:0];
  assign cout_d = carry[NGRP];
  assign ovf_d  = c3_unused[NGRP-1] ^ cout_d;
  assign pg_d   = &p_ext[NGRP-1:0];
  assign gg_d   = gen_full_unused[NGRP];

  // stage 1: capture operands and group P/G when the pipe can advance
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q  <= 1'b0;
      a1_q  <= '0;
      b1_q  <= '0;
      c1_q  <= 1'b0;
      gpg_q <= '0;
    end else if (adv1) begin
      v1_q  <= bus.in_valid;
      a1_q  <= bus.a;
      b1_q  <= bx;
      c1_q  <= cx;
      gpg_q <= gpg_d;
    end
  end

  // stage 2: register final result unless the consumer is stalling
  always_ff @(posedge clk) begin
    if (rst) begin
      v2_q   <= 1'b0;
      s_q    <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      pg_q   <= 1'b0;
      gg_q   <= 1'b0;
    end else if (adv2) begin
      v2_q   <= v1_q;
      s_q    <= s_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
      pg_q   <= pg_d;
      gg_q   <= gg_d;
    end
  end

  assign bus.out_valid = v2_q;
  assign bus.s         = s_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.pg        = pg_q;
  assign bus.gg        = gg_q;
endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder at WIDTH=16 and WIDTH=32.
// Expected results come from plain integer arithmetic.
module tb_cla_pipe_adder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cla_pipe_adder_if #(.WIDTH(16)) bus16 ();
  cla_pipe_adder_if #(.WIDTH(32)) bus32 ();

  cla_pipe_adder #(.WIDTH(16)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16.slave)
  );

  cla_pipe_adder #(.WIDTH(32)) dut32 (
    .clk (clk),
    .rst (rst),
    .bus (bus32.slave)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
  } op_t;

  typedef struct {
    logic [31:0] s;
    logic        cout;
    logic        ovf;
    logic        pg;
    logic        gg;
  } res_t;

  typedef struct {
    op_t  op;
    res_t r;
  } vec_t;

  res_t expq[$];

  function automatic res_t model(int w, op_t op);
    longint unsigned m, a, bl, bb, full, half;
    res_t r;
    m    = (64'd1 << w) - 1;
    a    = 64'(op.a) & m;
    bl   = 64'(op.b);
    bb   = op.sub ? (~bl & m) : (bl & m);
    full = a + bb + (op.sub ? 64'd1 : 64'(op.cin));
    half = a + bb;
    r.s    = 32'(full & m);
    r.cout = full[w];
    r.ovf  = (a[w-1] == bb[w-1]) && (full[w-1] != a[w-1]);
    r.pg   = ((a ^ bb) & m) == m;
    r.gg   = half[w];
    return r;
  endfunction

  function automatic op_t rand_op();
    op_t op;
    op.a   = $urandom;
    op.b   = $urandom;
    op.cin = 1'($urandom_range(0, 1));
    op.sub = 1'($urandom_range(0, 1));
    return op;
  endfunction

  task automatic set16(input logic v, input op_t op, input logic ordy);
    bus16.in_valid  = v;
    bus16.a         = op.a[15:0];
    bus16.b         = op.b[15:0];
    bus16.cin       = op.cin;
    bus16.sub       = op.sub;
    bus16.out_ready = ordy;
  endtask

  task automatic set32(input logic v, input op_t op, input logic ordy);
    bus32.in_valid  = v;
    bus32.a         = op.a;
    bus32.b         = op.b;
    bus32.cin       = op.cin;
    bus32.sub       = op.sub;
    bus32.out_ready = ordy;
  endtask

  task automatic test_reset();
    op_t z;
    z = '{32'h0, 32'h0, 1'b0, 1'b0};
    rst = 1'b1;
    set16(1'b0, z, 1'b0);
    set32(1'b0, z, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (bus16.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid got %b want 0", bus16.out_valid);
    end
    checks++;
    if ({bus16.s, bus16.cout, bus16.ovf, bus16.pg, bus16.gg} !== 20'h0) begin
      errors++;
      $display("FAIL reset_payload got s=%h c=%b o=%b p=%b g=%b want 0",
               bus16.s, bus16.cout, bus16.ovf, bus16.pg, bus16.gg);
    end
    checks++;
    if (bus16.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b want 1", bus16.in_ready);
    end
    checks++;
    if ({bus32.out_valid, bus32.s, bus32.cout} !== 34'h0) begin
      errors++;
      $display("FAIL reset_w32 got v=%b s=%h want 0", bus32.out_valid, bus32.s);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({bus16.out_valid, bus16.s} !== 17'h0) begin
      errors++;
      $display("FAIL reset_idle got v=%b s=%h want 0", bus16.out_valid, bus16.s);
    end
  endtask

  task automatic test_vectors16();
    vec_t v[6];
    v[0] = '{'{32'h0001, 32'h0000, 1'b0, 1'b0}, '{32'h0001, 1'b0, 1'b0, 1'b0, 1'b0}};
    v[1] = '{'{32'hFFFF, 32'h0001, 1'b0, 1'b0}, '{32'h0000, 1'b1, 1'b0, 1'b0, 1'b1}};
    v[2] = '{'{32'h0005, 32'h0007, 1'b0, 1'b1}, '{32'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0}};
    v[3] = '{'{32'h8000, 32'h0001, 1'b0, 1'b1}, '{32'h7FFF, 1'b1, 1'b1, 1'b0, 1'b1}};
    v[4] = '{'{32'h7FFF, 32'h0001, 1'b0, 1'b0}, '{32'h8000, 1'b0, 1'b1, 1'b0, 1'b0}};
    v[5] = '{'{32'hFFFF, 32'h0000, 1'b1, 1'b0}, '{32'h0000, 1'b1, 1'b0, 1'b1, 1'b0}};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      set16(1'b1, v[i].op, 1'b1);
      #1;
      checks++;
      if (bus16.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL vec%0d_in_ready got %b want 1", i, bus16.in_ready);
      end
      @(negedge clk);
      set16(1'b0, v[i].op, 1'b1);
      #1;
      checks++;
      if (bus16.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL vec%0d_early got out_valid=%b want 0", i, bus16.out_valid);
      end
      @(negedge clk);
      #1;
      checks++;
      if ({bus16.out_valid, bus16.s, bus16.cout, bus16.ovf, bus16.pg, bus16.gg} !==
          {1'b1, v[i].r.s[15:0], v[i].r.cout, v[i].r.ovf, v[i].r.pg, v[i].r.gg}) begin
        errors++;
        $display("FAIL vec%0d got v=%b s=%h c%b o%b p%b g%b want v=1 s=%h c%b o%b p%b g%b",
                 i, bus16.out_valid, bus16.s, bus16.cout, bus16.ovf, bus16.pg, bus16.gg,
                 v[i].r.s[15:0], v[i].r.cout, v[i].r.ovf, v[i].r.pg, v[i].r.gg);
      end
    end
  endtask

  task automatic test_back_to_back();
    op_t  op;
    res_t r;
    int   got = 0;
    int   last = -1;
    int   gaps = 0;
    expq.delete();
    for (int cyc = 0; cyc < 16; cyc++) begin
      @(negedge clk);
      if (cyc < 8) begin
        op = rand_op();
        set16(1'b1, op, 1'b1);
      end else begin
        set16(1'b0, op, 1'b1);
      end
      #1;
      if (cyc < 8) begin
        checks++;
        if (bus16.in_ready !== 1'b1) begin
          errors++;
          $display("FAIL b2b_in_ready cyc%0d got %b want 1", cyc, bus16.in_ready);
        end else begin
          expq.push_back(model(16, op));
        end
      end
      if (bus16.out_valid === 1'b1) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL b2b_extra got s=%h want no result", bus16.s);
        end else begin
          r = expq.pop_front();
          if ({bus16.s, bus16.cout, bus16.ovf, bus16.pg, bus16.gg} !==
              {r.s[15:0], r.cout, r.ovf, r.pg, r.gg}) begin
            errors++;
            $display("FAIL b2b_data #%0d got s=%h c%b o%b p%b g%b want s=%h c%b o%b p%b g%b",
                     got, bus16.s, bus16.cout, bus16.ovf, bus16.pg, bus16.gg,
                     r.s[15:0], r.cout, r.ovf, r.pg, r.gg);
          end
        end
        if (last >= 0 && cyc != last + 1) gaps++;
        last = cyc;
        got++;
      end
    end
    checks++;
    if (got != 8 || gaps != 0) begin
      errors++;
      $display("FAIL b2b_count got %0d results %0d gaps want 8 results 0 gaps", got, gaps);
    end
  endtask

  task automatic test_stall();
    op_t  ops[3];
    res_t r;
    int   idx = 0;
    int   got = 0;
    expq.delete();
    for (int i = 0; i < 3; i++) ops[i] = rand_op();
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      set16(1'b1, ops[idx], 1'b0);
      #1;
      if (bus16.out_valid === 1'b1 && expq.size() > 0) begin
        checks++;
        if (bus16.s !== expq[0].s[15:0]) begin
          errors++;
          $display("FAIL stall_hold got s=%h want %h", bus16.s, expq[0].s[15:0]);
        end
      end
      if (bus16.in_ready === 1'b1 && idx < 2) begin
        expq.push_back(model(16, ops[idx]));
        idx++;
      end else if (bus16.in_ready === 1'b1) begin
        idx++;
      end
    end
    checks++;
    if (idx != 2 || bus16.in_ready !== 1'b0 || bus16.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL stall_fill got accepted=%0d in_ready=%b out_valid=%b want 2 0 1",
               idx, bus16.in_ready, bus16.out_valid);
    end
    if (idx > 2) idx = 2;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      if (idx < 3) set16(1'b1, ops[idx], 1'b1);
      else set16(1'b0, ops[0], 1'b1);
      #1;
      if (idx < 3 && bus16.in_ready === 1'b1) begin
        expq.push_back(model(16, ops[idx]));
        idx++;
      end
      if (bus16.out_valid === 1'b1) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL stall_extra got s=%h want no result", bus16.s);
        end else begin
          r = expq.pop_front();
          if ({bus16.s, bus16.cout, bus16.ovf} !== {r.s[15:0], r.cout, r.ovf}) begin
            errors++;
            $display("FAIL stall_data #%0d got s=%h c%b o%b want s=%h c%b o%b",
                     got, bus16.s, bus16.cout, bus16.ovf, r.s[15:0], r.cout, r.ovf);
          end
        end
        got++;
      end
    end
    checks++;
    if (got != 3 || idx != 3) begin
      errors++;
      $display("FAIL stall_count got %0d delivered %0d accepted want 3 3", got, idx);
    end
  endtask

  task automatic test_reset_flush();
    op_t op;
    int  stale = 0;
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk);
      op = rand_op();
      set16(1'b1, op, 1'b0);
    end
    #1;
    checks++;
    if (bus16.in_ready !== 1'b0 || bus16.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL flush_full got in_ready=%b out_valid=%b want 0 1",
               bus16.in_ready, bus16.out_valid);
    end
    @(negedge clk);
    rst = 1'b1;
    set16(1'b1, rand_op(), 1'b1);
    @(negedge clk);
    rst = 1'b0;
    set16(1'b0, op, 1'b1);
    #1;
    checks++;
    if ({bus16.out_valid, bus16.s, bus16.in_ready} !== {17'h0, 1'b1}) begin
      errors++;
      $display("FAIL flush_state got v=%b s=%h rdy=%b want 0 0000 1",
               bus16.out_valid, bus16.s, bus16.in_ready);
    end
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      #1;
      if (bus16.out_valid !== 1'b0) stale++;
    end
    checks++;
    if (stale != 0) begin
      errors++;
      $display("FAIL flush_stale got %0d stale results want 0", stale);
    end
    expq.delete();
  endtask

  task automatic test_width32();
    vec_t v[7];
    res_t r;
    int   seen;
    v[0] = '{'{32'hFFFFFFFF, 32'h1, 1'b0, 1'b0}, '{32'h0, 1'b1, 1'b0, 1'b0, 1'b1}};
    v[1] = '{'{32'h7FFFFFFF, 32'h1, 1'b0, 1'b0}, '{32'h80000000, 1'b0, 1'b1, 1'b0, 1'b0}};
    v[2] = '{'{32'h80000000, 32'h1, 1'b0, 1'b1}, '{32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b1}};
    v[3] = '{'{32'hFFFFFFFF, 32'h0, 1'b1, 1'b0}, '{32'h0, 1'b1, 1'b0, 1'b1, 1'b0}};
    for (int i = 4; i < 7; i++) begin
      v[i].op = rand_op();
      v[i].r  = model(32, v[i].op);
    end
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      set32(1'b1, v[i].op, 1'b1);
      @(negedge clk);
      set32(1'b0, v[i].op, 1'b1);
      seen = 0;
      for (int w = 0; w < 4 && seen == 0; w++) begin
        #1;
        if (bus32.out_valid === 1'b1) begin
          seen = 1;
          r = v[i].r;
          checks++;
          if ({bus32.s, bus32.cout, bus32.ovf, bus32.pg, bus32.gg} !==
              {r.s, r.cout, r.ovf, r.pg, r.gg}) begin
            errors++;
            $display("FAIL w32_vec%0d got s=%h c%b o%b p%b g%b want s=%h c%b o%b p%b g%b",
                     i, bus32.s, bus32.cout, bus32.ovf, bus32.pg, bus32.gg,
                     r.s, r.cout, r.ovf, r.pg, r.gg);
          end
        end
        @(negedge clk);
      end
      if (seen == 0) begin
        checks++;
        errors++;
        $display("FAIL w32_vec%0d_timeout got no out_valid want one result", i);
      end
    end
  endtask

  initial begin
    test_reset();
    test_vectors16();
    test_back_to_back();
    test_stall();
    test_reset_flush();
    test_width32();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
